zoom_control: RTL and testbench

//  Input-side producer of the zoom selection consumed by the 7-seg display driver and the image pipeline.

---
 rtl/zoom_control_pkg.sv | 27 ++
 rtl/zoom_control_input_debounce.sv | 48 ++++
 rtl/zoom_control.sv | 186 ++++++++++++++++++
 tb/tb_zoom_control.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_control_pkg.sv
// Shared encodings for the zoom selection: level codes, one-hot algorithm
// codes and the request FSM states, plus the algorithm-code validity check.
// Optional feature macro used by the design: ZOOM_CTRL_WRAP_EN.
package zoom_control_pkg;

  localparam logic [1:0] ZOOM_2X = 2'b00;
  localparam logic [1:0] ZOOM_4X = 2'b01;
  localparam logic [1:0] ZOOM_8X = 2'b10;

  localparam logic [3:0] ALG_REPX = 4'b0001;
  localparam logic [3:0] ALG_VIN  = 4'b0010;
  localparam logic [3:0] ALG_VOUT = 4'b0100;
  localparam logic [3:0] ALG_MBCS = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_BUSY  = 2'b10
  } state_t;

  // True only for the four legal algorithm codes (exactly one bit set).
  function automatic logic is_valid_alg(input logic [3:0] code);
    return (code == ALG_REPX) || (code == ALG_VIN) ||
           (code == ALG_VOUT) || (code == ALG_MBCS);
  endfunction

endpackage

// File: rtl/zoom_control_input_debounce.sv
// One-bit input conditioner: 2-FF synchroniser followed by a stability
// counter. The output only takes a new value after the synchronised input
// has stayed unchanged for DEBOUNCE_CYCLES cycles.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   din         raw asynchronous input
//   dout        debounced level (RESET_VAL after reset)
module zoom_control_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             sync_prev;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, change detector and saturating stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= RESET_VAL;
      sync2     <= RESET_VAL;
      sync_prev <= RESET_VAL;
      cnt       <= '0;
      dout      <= RESET_VAL;
    end else begin
      sync1     <= din;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (sync2 != sync_prev) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        dout <= sync_prev;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/zoom_control.sv
// Zoom selection producer: debounces the two zoom keys and the four
// algorithm switches, steps the zoom level, validates the algorithm code and
// issues a one-cycle start request whenever the committed configuration
// changes (coalescing changes that arrive while a job is running).
// Macro: ZOOM_CTRL_WRAP_EN - when defined the level wraps 8x->2x / 2x->8x
// instead of saturating.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   key_zoom_in_n       raw active-low zoom-in key
//   key_zoom_out_n      raw active-low zoom-out key
//   sw[3:0]             raw algorithm switches
//   proc_done           pipeline job-finished pulse
//   zoom_level_select   00=2x, 01=4x, 10=8x
//   zoom_type_select    validated one-hot algorithm, 0000 when invalid
//   sw_invalid          debounced switches not exactly one-hot
//   start               one-cycle job request
//   busy                job outstanding
module zoom_control
  import zoom_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_zoom_in_n,
  input  logic       key_zoom_out_n,
  input  logic [3:0] sw,
  input  logic       proc_done,
  output logic [1:0] zoom_level_select,
  output logic [3:0] zoom_type_select,
  output logic       sw_invalid,
  output logic       start,
  output logic       busy
);

  logic       key_in_db;
  logic       key_out_db;
  logic [3:0] sw_db;

  logic       key_in_prev;
  logic       key_out_prev;
  logic       press_in;
  logic       press_out;

  logic [1:0] level_next;
  logic [3:0] type_next;
  logic       invalid_next;
  logic       cfg_change;

  state_t     state;
  state_t     state_next;
  logic       pending;
  logic       pending_next;
  logic       start_next;
  logic       busy_next;

  // Keys idle high; switches come out of reset as 0000.
  zoom_control_input_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_db_key_in (
    .clk   (clk),
    .reset (reset),
    .din   (key_zoom_in_n),
    .dout  (key_in_db)
  );

  zoom_control_input_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_db_key_out (
    .clk   (clk),
    .reset (reset),
    .din   (key_zoom_out_n),
    .dout  (key_out_db)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sw_db
    zoom_control_input_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_db_sw (
      .clk   (clk),
      .reset (reset),
      .din   (sw[i]),
      .dout  (sw_db[i])
    );
  end

  // Press = falling edge of the debounced (active-low) key.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_in_prev  <= 1'b1;
      key_out_prev <= 1'b1;
      press_in     <= 1'b0;
      press_out    <= 1'b0;
    end else begin
      key_in_prev  <= key_in_db;
      key_out_prev <= key_out_db;
      press_in     <= key_in_prev & ~key_in_db;
      press_out    <= key_out_prev & ~key_out_db;
    end
  end

  // Next level/type and change detection; simultaneous presses cancel.
  always_comb begin
    level_next = zoom_level_select;
    if (press_in && !press_out) begin
      case (zoom_level_select)
        ZOOM_2X: level_next = ZOOM_4X;
        ZOOM_4X: level_next = ZOOM_8X;
`ifdef ZOOM_CTRL_WRAP_EN
        ZOOM_8X: level_next = ZOOM_2X;
`else
        ZOOM_8X: level_next = ZOOM_8X;
`endif
        default: level_next = ZOOM_2X;
      endcase
    end else if (press_out && !press_in) begin
      case (zoom_level_select)
`ifdef ZOOM_CTRL_WRAP_EN
        ZOOM_2X: level_next = ZOOM_8X;
`else
        ZOOM_2X: level_next = ZOOM_2X;
`endif
        ZOOM_4X: level_next = ZOOM_2X;
        ZOOM_8X: level_next = ZOOM_4X;
        default: level_next = ZOOM_2X;
      endcase
    end
    invalid_next = !is_valid_alg(sw_db);
    type_next    = invalid_next ? 4'b0000 : sw_db;
    cfg_change   = (level_next != zoom_level_select) || (type_next != zoom_type_select);
  end

  // Configuration registers update regardless of the request FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      zoom_level_select <= ZOOM_2X;
      zoom_type_select  <= 4'b0000;
      sw_invalid        <= 1'b1;
    end else begin
      zoom_level_select <= level_next;
      zoom_type_select  <= type_next;
      sw_invalid        <= invalid_next;
    end
  end

  // Request FSM next state; a change in the START cycle re-arms pending.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      ST_IDLE: begin
        if (pending && !sw_invalid) state_next = ST_START;
      end
      ST_START: begin
        state_next   = ST_BUSY;
        pending_next = 1'b0;
      end
      ST_BUSY: begin
        if (proc_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (cfg_change) pending_next = 1'b1;
    start_next = (state_next == ST_START);
    busy_next  = (state_next == ST_BUSY);
  end

  // Request FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      start   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      start   <= start_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_zoom_control.sv
// Self-checking bench for zoom_control (DEBOUNCE_CYCLES=4): directed
// scenarios plus randomized key/switch actions against a behavioural model.
// Honours ZOOM_CTRL_WRAP_EN when the bundle is built with it.
module tb_zoom_control;

`ifdef ZOOM_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       key_zoom_in_n;
  logic       key_zoom_out_n;
  logic [3:0] sw;
  logic       proc_done;
  logic [1:0] zoom_level_select;
  logic [3:0] zoom_type_select;
  logic       sw_invalid;
  logic       start;
  logic       busy;

  zoom_control #(.DEBOUNCE_CYCLES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .key_zoom_in_n     (key_zoom_in_n),
    .key_zoom_out_n    (key_zoom_out_n),
    .sw                (sw),
    .proc_done         (proc_done),
    .zoom_level_select (zoom_level_select),
    .zoom_type_select  (zoom_type_select),
    .sw_invalid        (sw_invalid),
    .start             (start),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int exp_starts = 0;
  bit done_hold = 1'b0;

  // Behavioural model: level as 0..2, committed type, outstanding request.
  int         m_level;
  logic [3:0] m_type;
  bit         m_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit one_hot(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  task automatic m_zoom(input int dir);
    int nl;
    nl = m_level + dir;
    if (nl > 2) nl = WRAP ? 0 : 2;
    if (nl < 0) nl = WRAP ? 2 : 0;
    if (nl != m_level) begin
      m_level   = nl;
      m_pending = 1'b1;
    end
  endtask

  task automatic m_sw(input logic [3:0] v);
    logic [3:0] t;
    t = one_hot(v) ? v : 4'b0000;
    if (t != m_type) begin
      m_type    = t;
      m_pending = 1'b1;
    end
  endtask

  task automatic m_settle();
    if (m_pending && m_type != 4'b0000) begin
      exp_starts++;
      m_pending = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || start !== 1'b0) && n < 300) begin
      tick(1);
      n++;
    end
    check($sformatf("%s_idle_timeout", tag), 32'(n < 300), 32'd1);
  endtask

  task automatic verify(input string tag);
    wait_idle(tag);
    check($sformatf("%s_level", tag), 32'(zoom_level_select), 32'(m_level));
    check($sformatf("%s_type", tag), 32'(zoom_type_select), 32'(m_type));
    check($sformatf("%s_invalid", tag), 32'(sw_invalid), 32'(m_type == 4'b0000));
    check($sformatf("%s_starts", tag), 32'(start_cnt), 32'(exp_starts));
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s_level", tag), 32'(zoom_level_select), 32'd0);
    check($sformatf("%s_type", tag), 32'(zoom_type_select), 32'd0);
    check($sformatf("%s_invalid", tag), 32'(sw_invalid), 32'd1);
    check($sformatf("%s_start", tag), 32'(start), 32'd0);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
  endtask

  task automatic press(input bit zin, input bit zout);
    key_zoom_in_n  = !zin;
    key_zoom_out_n = !zout;
    tick(10);
    key_zoom_in_n  = 1'b1;
    key_zoom_out_n = 1'b1;
    tick(40);
  endtask

  task automatic set_sw(input logic [3:0] v);
    sw = v;
    tick(40);
  endtask

  // Start pulse monitor: counts pulses, checks width and busy follow-up.
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_start === 1'b1 && reset === 1'b0) check("busy_after_start", 32'(busy), 32'd1);
      if (start === 1'b1) begin
        start_cnt++;
        check("start_width", 32'(prev_start), 32'd0);
      end
      prev_start = start;
    end
  end

  // Pipeline stand-in: answers each start with proc_done after a delay.
  initial begin
    int d;
    proc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        d = int'($urandom_range(2, 6));
        tick(d);
        while (done_hold) tick(1);
        proc_done = 1'b1;
        tick(1);
        proc_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [3:0] v;

    reset          = 1'b1;
    key_zoom_in_n  = 1'b1;
    key_zoom_out_n = 1'b1;
    sw             = 4'b0000;
    m_level        = 0;
    m_type         = 4'b0000;
    m_pending      = 1'b0;
    tick(3);
    check_reset_vals("rst");
    reset = 1'b0;
    tick(2);

    // 1: stable valid switches produce one job
    m_sw(4'b0010); m_settle();
    set_sw(4'b0010);
    verify("t1");

    // 2: zoom-in presses; first one also checks change-to-start latency
    key_zoom_in_n = 1'b0;
    n = 0;
    while (zoom_level_select == 2'd0 && n < 50) begin
      tick(1);
      n++;
    end
    check("t2_level_seen", 32'(n < 50), 32'd1);
    tick(1);
    check("t2_latency", 32'(start), 32'd1);
    tick(5);
    key_zoom_in_n = 1'b1;
    tick(40);
    m_zoom(1); m_settle();
    verify("t2a");
    m_zoom(1); m_settle(); press(1'b1, 1'b0); verify("t2b");
    m_zoom(1); m_settle(); press(1'b1, 1'b0); verify("t2c");

    // 3: bouncing key gives one step; short glitch gives none
    key_zoom_out_n = 1'b0; tick(2);
    key_zoom_out_n = 1'b1; tick(2);
    key_zoom_out_n = 1'b0; tick(2);
    key_zoom_out_n = 1'b1; tick(2);
    key_zoom_out_n = 1'b0; tick(10);
    key_zoom_out_n = 1'b1; tick(40);
    m_zoom(-1); m_settle();
    verify("t3_bounce");
    key_zoom_out_n = 1'b0; tick(3);
    key_zoom_out_n = 1'b1; tick(40);
    verify("t3_glitch");

    // 4: invalid switches hold the request, valid code releases it
    m_sw(4'b0110); m_settle(); set_sw(4'b0110); verify("t4_inv");
    m_sw(4'b0100); m_settle(); set_sw(4'b0100); verify("t4_ok");

    // 5: changes while busy coalesce into one start after done
    done_hold = 1'b1;
    m_sw(4'b1000); m_settle();
    sw = 4'b1000;
    tick(20);
    check("t5_busy", 32'(busy), 32'd1);
    m_zoom(1);
    key_zoom_in_n = 1'b0; tick(10);
    key_zoom_in_n = 1'b1; tick(30);
    m_sw(4'b0001);
    sw = 4'b0001;
    tick(30);
    check("t5_no_start", 32'(start_cnt), 32'(exp_starts));
    m_settle();
    done_hold = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    check("t5_done_seen", 32'(n < 100), 32'd1);
    tick(1);
    check("t5_restart", 32'(start), 32'd1);
    verify("t5");

    // both keys together: no level change, no job
    press(1'b1, 1'b1);
    verify("both_keys");

    // 6: reset while busy returns everything to reset values
    done_hold = 1'b1;
    m_sw(4'b0010); m_settle();
    sw = 4'b0010;
    tick(20);
    check("t6_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    check_reset_vals("t6_rst");
    reset     = 1'b0;
    done_hold = 1'b0;
    m_level   = 0;
    m_type    = 4'b0000;
    m_pending = 1'b0;
    m_sw(sw); m_settle();
    tick(40);
    verify("t6_after");

    // randomized actions against the model
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0, 1: begin m_zoom(1);  m_settle(); press(1'b1, 1'b0); end
        2, 3: begin m_zoom(-1); m_settle(); press(1'b0, 1'b1); end
        4: begin
          v = 4'b0001 << $urandom_range(0, 3);
          m_sw(v); m_settle(); set_sw(v);
        end
        default: begin
          v = 4'($urandom_range(0, 15));
          m_sw(v); m_settle(); set_sw(v);
        end
      endcase
      verify($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
